// File: rtl/encode_mul_rr_sched.sv
// Round-robin scheduler that shares one pipelined signed multiplier among
// NUM_REQ requesters. A tag pipe runs alongside the multiplier so each product
// comes back with the id of the requester that issued it. Result backpressure
// stalls the multiplier and the tag pipe together through mul_ce.
module encode_mul_rr_sched #(
  parameter int NUM_REQ     = 4,
  parameter int ID_WIDTH    = 2,
  parameter int A_WIDTH     = 40,
  parameter int B_WIDTH     = 25,
  parameter int P_WIDTH     = 64,
  parameter int MUL_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
  output logic                       mul_ce,
  output logic [A_WIDTH-1:0]         mul_din0,
  output logic [B_WIDTH-1:0]         mul_din1,
  input  logic [P_WIDTH-1:0]         mul_dout,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [P_WIDTH-1:0]         res_data,
  output logic [ID_WIDTH-1:0]        res_id
);

  localparam int TAIL = MUL_LATENCY - 1;
  // Requester count in the widened search width, used for the modulo wrap.
  localparam logic [ID_WIDTH:0] NREQ_X = (ID_WIDTH+1)'(NUM_REQ);

  // Index 0 is the issue slot, TAIL lines up with mul_dout.
  logic [MUL_LATENCY-1:0]               vld_pipe_q, vld_pipe_d;
  logic [MUL_LATENCY-1:0][ID_WIDTH-1:0] id_pipe_q, id_pipe_d;
  logic [ID_WIDTH-1:0]                  rr_ptr_q, rr_ptr_d;

  logic                advance;
  logic                grant_any;
  logic                issue;
  logic [ID_WIDTH-1:0] grant_id;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_WIDTH:0]   cand;

  // The pipe may move when its tail is empty or the tail result is being taken.
  assign advance = !reset && (!vld_pipe_q[TAIL] || res_ready);
  assign mul_ce  = advance;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (ID_WIDTH+1)'(k);
      if (cand >= NREQ_X) cand = cand - NREQ_X;
      if (!grant_any && req_valid[cand[ID_WIDTH-1:0]]) begin
        grant_any = 1'b1;
        grant_id  = cand[ID_WIDTH-1:0];
      end
    end
  end

  // One-hot grant and operand mux; operands are zero when nobody is granted.
  always_comb begin
    grant    = '0;
    mul_din0 = '0;
    mul_din1 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = grant_any && (grant_id == ID_WIDTH'(i));
      if (grant[i]) begin
        mul_din0 = req_a[i*A_WIDTH +: A_WIDTH];
        mul_din1 = req_b[i*B_WIDTH +: B_WIDTH];
      end
    end
  end

  assign req_ready = advance ? grant : '0;
  assign issue     = |(req_valid & req_ready);

  // Tag pipe shifts in lockstep with the multiplier; an idle advance is a bubble.
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    id_pipe_d  = id_pipe_q;
    rr_ptr_d   = rr_ptr_q;
    if (advance) begin
      vld_pipe_d[0] = issue;
      id_pipe_d[0]  = grant_id;
      for (int s = 1; s < MUL_LATENCY; s++) begin
        vld_pipe_d[s] = vld_pipe_q[s-1];
        id_pipe_d[s]  = id_pipe_q[s-1];
      end
    end
    if (issue) rr_ptr_d = grant_id;
  end

  // State registers; pointer resets to the last id so requester 0 wins first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe_q <= '0;
      id_pipe_q  <= '0;
      rr_ptr_q   <= ID_WIDTH'(NUM_REQ - 1);
    end else begin
      vld_pipe_q <= vld_pipe_d;
      id_pipe_q  <= id_pipe_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign res_valid = vld_pipe_q[TAIL];
  assign res_id    = id_pipe_q[TAIL];
  assign res_data  = mul_dout;

endmodule
